pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The block SHALL have parameter INIT_LIVES, default 3, balls per game (1..3).
REQ-002 The block SHALL have parameter WAIT_FRAMES, default 120, frames held in NEWBALL/OVER (1..127).
REQ-003 The block SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port btn  input  2  debounced button levels, active-high.
REQ-006 The block SHALL have port refr_tick  input  1  one-cycle pulse once per video frame.
REQ-007 The block SHALL have port hit  input  1  one-cycle pulse, ball struck paddle.
REQ-008 The block SHALL have port miss  input  1  one-cycle pulse, ball passed paddle.
REQ-009 The block SHALL have port gra_still  output  1  freeze ball/paddle motion.
REQ-010 The block SHALL have port ball_rst  output  1  one-cycle pulse, re-centre ball.
REQ-011 The block SHALL have port score  output  8  two BCD digits, [7:4] tens, [3:0] units.
REQ-012 The block SHALL have port lives  output  2  balls remaining including current.
REQ-013 The block SHALL have port state  output  2  NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3, for text overlay.

Function
REQ-014 btn_go SHALL be the rising edge of either btn bit, from a 2-bit registered previous value.
REQ-015 NEWGAME: on btn_go, next state PLAY; all other inputs ignored.
REQ-016 PLAY: miss with lives>1 -> NEWBALL, lives decremented; miss with lives==1 -> OVER, lives becomes 0.
REQ-017 PLAY: hit SHALL increment score by one in BCD; units 9 -> 0 with tens carry; 99 -> 00 wrap.
REQ-018 hit and miss in the same PLAY cycle SHALL both take effect: score increments and miss transition occurs.
REQ-019 hit, miss outside PLAY and btn_go outside NEWGAME SHALL be ignored.
REQ-020 Entry to NEWBALL or OVER SHALL load frame counter with WAIT_FRAMES; each refr_tick decrements it.
REQ-021 Exit from NEWBALL (-> PLAY) or OVER (-> NEWGAME) SHALL occur on the edge where refr_tick=1 and counter==1: exactly WAIT_FRAMES ticks.
REQ-022 Entry to NEWGAME from OVER SHALL clear score to 00 and reload lives to INIT_LIVES in the same edge.
REQ-023 ball_rst SHALL be registered, high exactly the first cycle in PLAY after every entry to PLAY.
REQ-024 gra_still SHALL be 0 only while state==PLAY, Moore-decoded, no added latency.
REQ-025 score, lives, state SHALL be registered outputs, changing only on the transition edge.

Reset
REQ-026 rst SHALL override all inputs in the same cycle.
REQ-027 Reset values: state NEWGAME, score 00, lives INIT_LIVES, ball_rst 0, gra_still 1, counter 0, btn previous 2'b11.
REQ-028 rst mid-operation in any state SHALL return to reset values with no ball_rst pulse; a button held through reset SHALL NOT produce btn_go.

Structure
REQ-029 State codes, INIT_LIVES and WAIT_FRAMES defaults, and counter width (7) SHALL live in a shared package pong_pkg.
REQ-030 The frame counter SHALL be one sub-module frame_timer: load, tick, done outputs; everything else is in pong_game_ctrl.

Verification
REQ-031 Reset, then btn 00->01 -> state 1 next edge, ball_rst high one cycle, gra_still 0, lives 3.
REQ-032 PLAY, score 0x09 and hit -> score 0x10; score 0x99 and hit -> score 0x00.
REQ-033 PLAY, lives 3, miss -> state 2, lives 2; 119 refr_ticks keep state 2; 120th -> state 1 with ball_rst pulse.
REQ-034 lives 1, hit and miss same cycle -> score +1, state 3, lives 0; after 120 refr_ticks -> state 0, score 00, lives 3.
REQ-035 btn held high across rst deassertion -> state stays 0; btn pulses during NEWBALL/OVER -> no effect.
REQ-036 rst asserted in NEWBALL with counter 50 -> next edge state 0, score 00, lives 3, counter 0, ball_rst 0.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_pkg : shared state codes, defaults and BCD helper for the pong controller
// Rev 1.0
//------------------------------------------------------------------------------
package pong_pkg;

  localparam int CNT_W           = 7;
  localparam int INIT_LIVES_DEF  = 3;
  localparam int WAIT_FRAMES_DEF = 120;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_game_ctrl_if : game-event inputs and status outputs of the pong controller
// Rev 1.0
//------------------------------------------------------------------------------
interface pong_game_ctrl_if;

  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic       ball_rst;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] state;

  modport master (
    output btn, refr_tick, hit, miss,
    input  gra_still, ball_rst, score, lives, state
  );

  modport slave (
    input  btn, refr_tick, hit, miss,
    output gra_still, ball_rst, score, lives, state
  );

endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl_frame_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// frame_timer : loadable down-counter of video frames, done on the last tick
// Rev 1.0
//------------------------------------------------------------------------------
module frame_timer
  import pong_pkg::*;
#(
  parameter int WAIT_FRAMES = WAIT_FRAMES_DEF
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_tick,
  output logic      o_done
);

  logic [CNT_W-1:0] r_count;

  assign o_done = i_tick && (r_count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(WAIT_FRAMES);
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_game_ctrl : pong game flow FSM -- start, play, ball loss, game over
// Rev 1.0
//------------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int INIT_LIVES  = INIT_LIVES_DEF,
  parameter int WAIT_FRAMES = WAIT_FRAMES_DEF
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pong_game_ctrl_if.slave bus
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_btn_prev;
  logic       w_btn_go;
  logic       w_load;
  logic       w_done;
  logic       w_score_inc;
  logic       w_lives_dec;
  logic       w_new_game;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic       r_ball_rst;

  // Previous value resets to all-ones so a button held through reset is not an edge.
  assign w_btn_go = |(bus.btn & ~r_btn_prev);

  frame_timer #(
    .WAIT_FRAMES(WAIT_FRAMES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_tick(bus.refr_tick),
    .o_done(w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NEWGAME;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_score_inc = 1'b0;
    w_lives_dec = 1'b0;
    w_new_game  = 1'b0;
    case (r_state)
      ST_NEWGAME: begin
        if (w_btn_go) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        w_score_inc = bus.hit;
        if (bus.miss) begin
          w_lives_dec = 1'b1;
          w_load      = 1'b1;
          w_next      = (r_lives > 2'd1) ? ST_NEWBALL : ST_OVER;
        end
      end
      ST_NEWBALL: begin
        if (w_done) w_next = ST_PLAY;
      end
      ST_OVER: begin
        if (w_done) begin
          w_next     = ST_NEWGAME;
          w_new_game = 1'b1;
        end
      end
      default: w_next = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_prev <= 2'b11;
      r_ball_rst <= 1'b0;
      r_score    <= 8'h00;
      r_lives    <= 2'(INIT_LIVES);
    end else begin
      r_btn_prev <= bus.btn;
      r_ball_rst <= (w_next == ST_PLAY) && (r_state != ST_PLAY);
      if (w_new_game) begin
        r_score <= 8'h00;
        r_lives <= 2'(INIT_LIVES);
      end else begin
        if (w_score_inc) r_score <= bcd_inc(r_score);
        if (w_lives_dec) r_lives <= r_lives - 2'd1;
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.gra_still = (r_state != ST_PLAY);
  assign bus.ball_rst  = r_ball_rst;
  assign bus.score     = r_score;
  assign bus.lives     = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pong_game_ctrl : vector table plus scoreboarded sequences for pong_game_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
module tb_pong_game_ctrl;

  typedef struct {
    logic         rst;
    logic [1:0]   btn;
    logic         tick;
    logic         hit;
    logic         miss;
    logic [1:0]   st;
    logic [7:0]   sc;
    logic [1:0]   lv;
    logic         br;
    logic         gs;
    logic [191:0] nm;
  } vec_t;

  typedef struct {
    logic [1:0]   st;
    logic [7:0]   sc;
    logic [1:0]   lv;
    logic         br;
    logic         gs;
    logic [191:0] nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .INIT_LIVES (3),
    .WAIT_FRAMES(120)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic chk(input logic [191:0] nm, input string fld,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %0s.%0s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic chk_cnt(input logic [191:0] nm, input int req);
    checks++;
    if (int'(dut.u_timer.r_count) != req) begin
      failures++;
      $display("FAIL %0s.counter actual=%0d required=%0d", nm,
               dut.u_timer.r_count, req);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = q.pop_front();
      chk(e.nm, "state",     8'(bus.state),     8'(e.st));
      chk(e.nm, "score",     bus.score,         e.sc);
      chk(e.nm, "lives",     8'(bus.lives),     8'(e.lv));
      chk(e.nm, "ball_rst",  8'(bus.ball_rst),  8'(e.br));
      chk(e.nm, "gra_still", 8'(bus.gra_still), 8'(e.gs));
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] b, input logic t,
                       input logic h, input logic m, input logic [1:0] st,
                       input logic [7:0] sc, input logic [1:0] lv,
                       input logic br, input logic gs, input logic [191:0] nm);
    exp_t e;
    rst           = r;
    bus.btn       = b;
    bus.refr_tick = t;
    bus.hit       = h;
    bus.miss      = m;
    e.st = st; e.sc = sc; e.lv = lv; e.br = br; e.gs = gs; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  initial begin
    bus.btn       = 2'b00;
    bus.refr_tick = 1'b0;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;

    //          rst btn    tk hit ms  st    sc     lv   br gs name
    tbl[0]  = '{1, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "reset"};
    tbl[1]  = '{1, 2'b00, 1, 1, 1, 2'd0, 8'h00, 2'd3, 0, 1, "reset_override"};
    tbl[2]  = '{0, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "idle"};
    tbl[3]  = '{0, 2'b00, 0, 1, 0, 2'd0, 8'h00, 2'd3, 0, 1, "hit_newgame"};
    tbl[4]  = '{0, 2'b00, 1, 0, 1, 2'd0, 8'h00, 2'd3, 0, 1, "miss_newgame"};
    tbl[5]  = '{0, 2'b01, 0, 0, 0, 2'd1, 8'h00, 2'd3, 1, 0, "go"};
    tbl[6]  = '{0, 2'b01, 0, 0, 0, 2'd1, 8'h00, 2'd3, 0, 0, "play_hold"};
    tbl[7]  = '{0, 2'b11, 0, 0, 0, 2'd1, 8'h00, 2'd3, 0, 0, "go_in_play"};
    tbl[8]  = '{0, 2'b00, 0, 1, 0, 2'd1, 8'h01, 2'd3, 0, 0, "hit1"};
    tbl[9]  = '{0, 2'b00, 1, 0, 0, 2'd1, 8'h01, 2'd3, 0, 0, "tick_play"};
    tbl[10] = '{0, 2'b00, 0, 1, 0, 2'd1, 8'h02, 2'd3, 0, 0, "hit2"};
    tbl[11] = '{0, 2'b00, 0, 0, 0, 2'd1, 8'h02, 2'd3, 0, 0, "idle_play"};

    for (int i = 0; i < 12; i++)
      apply(tbl[i].rst, tbl[i].btn, tbl[i].tick, tbl[i].hit, tbl[i].miss,
            tbl[i].st, tbl[i].sc, tbl[i].lv, tbl[i].br, tbl[i].gs, tbl[i].nm);

    // Score through 09->10 and 99->00.
    for (int n = 3; n <= 100; n++)
      apply(0, 2'b00, 0, 1, 0, 2'd1, bcd(n % 100), 2'd3, 0, 0, "hit_run");

    // Lose a ball with 3 lives, disturb NEWBALL with ignored inputs.
    apply(0, 2'b00, 0, 0, 1, 2'd2, 8'h00, 2'd2, 0, 1, "miss_l3");
    chk_cnt("miss_l3", 120);
    for (int k = 1; k <= 119; k++) begin
      apply(0, 2'b00, 1, 0, 0, 2'd2, 8'h00, 2'd2, 0, 1, "newball_wait");
      if (k % 10 == 0) begin
        apply(0, 2'b01, 0, 1, 1, 2'd2, 8'h00, 2'd2, 0, 1, "newball_disturb");
        apply(0, 2'b00, 0, 0, 0, 2'd2, 8'h00, 2'd2, 0, 1, "newball_release");
      end
    end
    apply(0, 2'b00, 1, 0, 0, 2'd1, 8'h00, 2'd2, 1, 0, "newball_exit");
    apply(0, 2'b00, 0, 0, 0, 2'd1, 8'h00, 2'd2, 0, 0, "ball_rst_one");

    // Second ball lost, back to PLAY with one life.
    apply(0, 2'b00, 0, 0, 1, 2'd2, 8'h00, 2'd1, 0, 1, "miss_l2");
    for (int k = 1; k <= 120; k++)
      apply(0, 2'b00, 1, 0, 0, (k == 120) ? 2'd1 : 2'd2, 8'h00, 2'd1,
            (k == 120), (k != 120), "newball2_wait");
    apply(0, 2'b00, 0, 0, 0, 2'd1, 8'h00, 2'd1, 0, 0, "play_l1");

    // Simultaneous hit and miss on the last life.
    apply(0, 2'b00, 0, 1, 1, 2'd3, 8'h01, 2'd0, 0, 1, "hit_miss_last");
    for (int k = 1; k <= 120; k++) begin
      if (k < 120)
        apply(0, 2'b00, 1, 0, 0, 2'd3, 8'h01, 2'd0, 0, 1, "over_wait");
      else
        apply(0, 2'b00, 1, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "over_exit");
      if (k % 20 == 0 && k < 120) begin
        apply(0, 2'b10, 0, 1, 0, 2'd3, 8'h01, 2'd0, 0, 1, "over_disturb");
        apply(0, 2'b00, 0, 0, 0, 2'd3, 8'h01, 2'd0, 0, 1, "over_release");
      end
    end
    apply(0, 2'b00, 0, 1, 0, 2'd0, 8'h00, 2'd3, 0, 1, "newgame_hit");

    // Button held across reset release must not start a game.
    apply(1, 2'b01, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "rst_btn_held");
    apply(1, 2'b01, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "rst_btn_held");
    for (int k = 0; k < 3; k++)
      apply(0, 2'b01, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "held_after_rst");
    apply(0, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "btn_release");
    apply(0, 2'b10, 0, 0, 0, 2'd1, 8'h00, 2'd3, 1, 0, "go_bit1");

    // Reset in the middle of a NEWBALL wait.
    apply(0, 2'b00, 0, 1, 0, 2'd1, 8'h01, 2'd3, 0, 0, "e_hit");
    apply(0, 2'b00, 0, 0, 1, 2'd2, 8'h01, 2'd2, 0, 1, "e_miss");
    for (int k = 1; k <= 70; k++) begin
      apply(0, 2'b00, 1, 0, 0, 2'd2, 8'h01, 2'd2, 0, 1, "e_wait");
      chk_cnt("e_wait", 120 - k);
    end
    apply(1, 2'b11, 1, 1, 1, 2'd0, 8'h00, 2'd3, 0, 1, "rst_newball");
    chk_cnt("rst_newball", 0);
    apply(0, 2'b00, 0, 0, 0, 2'd0, 8'h00, 2'd3, 0, 1, "post_rst");
    chk_cnt("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
